// File: rtl/if_stage_pipeline.sv
// Instruction-fetch stage: PC register, next-PC select with redirect/stall, and IF/ID register.
// Optional stall/flush performance counters are compiled in with IF_STAGE_PERF_CNT_EN.
module if_stage_pipeline #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             write_IF_ID,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        redirect;

    assign redirect = jump | branch_taken;
    assign pc_plus4 = pc_q + 32'd4;

    // Redirects take priority over a hazard stall so a squashed path never lingers.
    always_comb begin
        pc_d = pc_q;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (jump) begin
            pc_d = {jump_target[31:2], 2'b00};
        end else if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (pc_write) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        if_id_pc4_d   = if_id_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (reset || redirect) begin
            if_id_pc4_d   = 32'h0000_0000;
            if_id_instr_d = 32'h0000_0000;
            if_id_valid_d = 1'b0;
        end else if (write_IF_ID) begin
            if_id_pc4_d   = pc_plus4;
            if_id_instr_d = imem_data;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        if_id_pc4_q   <= if_id_pc4_d;
        if_id_instr_q <= if_id_instr_d;
        if_id_valid_q <= if_id_valid_d;
    end

    assign imem_addr   = pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: a stall cycle is one where IF/ID holds without being flushed.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!write_IF_ID && !redirect && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_if_stage_pipeline.sv
// Scoreboard bench for if_stage_pipeline: directed vectors push expected post-edge state,
// a monitor pops and compares one entry after each rising edge.
module tb_if_stage_pipeline;

    localparam logic [31:0] RstPc = 32'h0000_0040;
    localparam logic [31:0] Key   = 32'hDEAD_0000;
`ifdef IF_STAGE_PERF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, pc_write, write_IF_ID, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_data, if_id_pc4, if_id_instr;
    logic        if_id_valid;
    logic [3:0]  stall_count, flush_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc4;
        logic        valid;
        int          sc;
        int          fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content is a fixed function of its address.
    assign imem_data = imem_addr ^ Key;

    if_stage_pipeline #(
        .RESET_PC (RstPc),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .write_IF_ID   (write_IF_ID),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        logic [31:0] ei;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ei = e.valid ? ((e.pc4 - 32'd4) ^ Key) : 32'h0;
                chk("imem_addr", imem_addr, e.addr);
                chk("if_id_pc4", if_id_pc4, e.pc4);
                chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
                chk("if_id_instr", if_id_instr, ei);
                chk("stall_count", {28'b0, stall_count}, CntEn ? 32'(e.sc) : 32'h0);
                chk("flush_count", {28'b0, flush_count}, CntEn ? 32'(e.fc) : 32'h0);
            end
        end
    end

    task automatic cyc(input bit rst, input bit pcw, input bit wr,
                       input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt,
                       input logic [31:0] ea, input logic [31:0] epc4, input bit ev,
                       input int es, input int ef);
        exp_t e;
        reset         = rst;
        pc_write      = pcw;
        write_IF_ID   = wr;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        e.addr = ea; e.pc4 = epc4; e.valid = ev; e.sc = es; e.fc = ef;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] ea, input logic [31:0] epc4, input int es, input int ef);
        cyc(0, 1, 1, 0, 32'h0, 0, 32'h0, ea, epc4, 1, es, ef);
    endtask

    initial begin
        // Reset: PC at RESET_PC, IF/ID empty, counters clear.
        cyc(1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h40, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h500, 1, 32'h600, 32'h40, 32'h0, 0, 0, 0);
        run(32'h44, 32'h44, 0, 0);
        run(32'h48, 32'h48, 0, 0);
        // Three-cycle load-use stall at 0x48.
        cyc(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h48, 32'h48, 1, 1, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h48, 32'h48, 1, 2, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h48, 32'h48, 1, 3, 0);
        run(32'h4C, 32'h4C, 3, 0);
        run(32'h50, 32'h50, 3, 0);
        // Taken branch to 0x103: target aligned, one bubble.
        cyc(0, 1, 1, 1, 32'h103, 0, 32'h0, 32'h100, 32'h0, 0, 3, 1);
        run(32'h104, 32'h104, 3, 1);
        run(32'h108, 32'h108, 3, 1);
        // Jump beats branch and overrides the stall.
        cyc(0, 0, 0, 1, 32'h300, 1, 32'h200, 32'h200, 32'h0, 0, 3, 2);
        run(32'h204, 32'h204, 3, 2);
        // PC held, IF/ID reloads the same instruction.
        cyc(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h204, 32'h208, 1, 3, 2);
        // PC advances, IF/ID holds.
        cyc(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h208, 32'h208, 1, 4, 2);
        // Jump to top of memory, then wrap to 0.
        cyc(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 0, 4, 3);
        run(32'h0, 32'h0, 4, 3);
        run(32'h4, 32'h4, 4, 3);
        // Long stall: stall counter saturates at 15.
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h4, 32'h4, 1, (4 + k > 15) ? 15 : 4 + k, 3);
        end
        // Reset mid-stall with a redirect pending: everything returns to reset values.
        cyc(1, 0, 0, 1, 32'h700, 1, 32'h800, 32'h40, 32'h0, 0, 0, 0);
        run(32'h44, 32'h44, 0, 0);
        run(32'h48, 32'h48, 0, 0);
        cyc(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h4C, 32'h4C, 1, 0, 0);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d entries left expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
